hazard_ctrl: RTL

- Parametrised successor to the pipeline's stall-only hazard detector. Sits beside the IF/ID/EX/MEM/WB pipeline registers and drives their enables, bubbles and flushes.
- Adds EX-stage operand forwarding selects, load-use stall, branch flush and a multi-cycle EX-op freeze FSM (divider/multiplier).
- Adds a saturating stall-cycle performance counter.
- Holds its own copy of the EX-stage source register numbers.

---
 rtl/hazard_ctrl.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for a classic IF/ID/EX/MEM/WB integer pipeline.
// It sits beside the pipeline registers and drives their enables, bubbles and
// flushes. It also selects EX operand forwarding and freezes the front end
// while a multi-cycle EX operation (divider/multiplier) is in progress. A
// saturating counter records how many cycles the front end was frozen.
//
// Optional feature macro: HAZARD_CTRL_FWD_EN
//   defined   : EX operand forwarding from MEM/WB is active. Only a load in EX
//               whose result is needed by ID causes a data stall.
//   undefined : fwd_a/fwd_b are tied to 00. ID stalls on any used source that
//               matches a register write pending in EX or MEM.
//
// Parameters:
//   REG_AW  register-address width
//   MC_LAT  cycles a multi-cycle op occupies EX (must be >= 2)
//   CNT_W   width of the stall performance counter
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   id_rs1/id_rs2, id_use_rs1/2      sources of the ID instruction and whether
//                                    it really reads them
//   ex_rd, ex_reg_write, ex_mem_read EX destination and status
//   ex_mc_start, ex_branch_taken     EX multi-cycle start / taken branch
//   mem_rd, mem_reg_write            MEM destination and write flag
//   wb_rd, wb_reg_write              WB destination and write flag
//   pc_en, if_id_en, id_ex_en        pipeline-register enables
//   id_ex_bubble, if_id_flush,
//   ex_mem_bubble                    NOP insertion into the named register
//   fwd_a, fwd_b                     EX operand select: 00 regfile, 01 WB,
//                                    10 MEM
//   mc_busy                          multi-cycle FSM is in BUSY
//   stall_cnt                        saturating count of frozen-PC cycles
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mc_start,
  input  logic              ex_branch_taken,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic              ex_mem_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mc_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // The down-counter only ever holds values 0 .. MC_LAT-2.
  localparam int MC_CW = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // True when a register write to rd (x0 excluded) feeds a used ID source.
  function automatic logic src_hit(input logic [REG_AW-1:0] rd,
                                   input logic              wr,
                                   input logic [REG_AW-1:0] rs1,
                                   input logic              use1,
                                   input logic [REG_AW-1:0] rs2,
                                   input logic              use2);
    return wr && (rd != '0) &&
           ((use1 && (rd == rs1)) || (use2 && (rd == rs2)));
  endfunction

  // EX operand select; MEM is younger than WB so it wins on a double match.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] m_rd,
                                         input logic              m_wr,
                                         input logic [REG_AW-1:0] w_rd,
                                         input logic              w_wr);
    if (m_wr && (m_rd != '0) && (m_rd == rs))
      return FWD_MEM;
    else if (w_wr && (w_rd != '0) && (w_rd == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  // ---------------------------------------------------------------------------
  // Multi-cycle EX freeze FSM
  // ---------------------------------------------------------------------------
  mc_state_t        mc_state_q;
  mc_state_t        mc_state_d;
  logic [MC_CW-1:0] mc_cnt_q;
  logic [MC_CW-1:0] mc_cnt_d;
  logic             mc_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      // Aborts any op in flight; no done cycle is produced.
      mc_state_q <= MC_IDLE;
      mc_cnt_q   <= '0;
    end else begin
      mc_state_q <= mc_state_d;
      mc_cnt_q   <= mc_cnt_d;
    end
  end

  // The start cycle itself already freezes, so the counter is loaded with
  // MC_LAT-2: start + (MC_LAT-2) counting cycles = MC_LAT-1 frozen cycles,
  // followed by one unfrozen done cycle in which the op leaves EX.
  always_comb begin
    mc_state_d = mc_state_q;
    mc_cnt_d   = mc_cnt_q;
    mc_stall   = 1'b0;
    unique case (mc_state_q)
      MC_IDLE: begin
        if (ex_mc_start) begin
          mc_stall   = 1'b1;
          mc_state_d = MC_BUSY;
          mc_cnt_d   = MC_CW'(MC_LAT - 2);
        end
      end
      MC_BUSY: begin
        // ex_mc_start is deliberately ignored here.
        if (mc_cnt_q != '0) begin
          mc_stall = 1'b1;
          mc_cnt_d = mc_cnt_q - 1'b1;
        end else begin
          mc_state_d = MC_IDLE;
        end
      end
      default: begin
        mc_state_d = MC_IDLE;
        mc_cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Data-hazard detection
  // ---------------------------------------------------------------------------
  logic ex_hit;
  logic data_stall;

  assign ex_hit = src_hit(ex_rd, ex_reg_write, id_rs1, id_use_rs1,
                          id_rs2, id_use_rs2);

`ifdef HAZARD_CTRL_FWD_EN
  // Only a load result cannot be forwarded in time for the dependent op.
  assign data_stall = ex_hit && ex_mem_read;
`else
  logic mem_hit;
  logic unused_fwd_inputs;

  // Without forwarding every pending EX/MEM write must reach the regfile
  // first. WB needs no stall because the regfile is write-first.
  assign mem_hit    = src_hit(mem_rd, mem_reg_write, id_rs1, id_use_rs1,
                              id_rs2, id_use_rs2);
  assign data_stall = ex_hit || mem_hit;

  // These inputs only matter when forwarding is built in.
  assign unused_fwd_inputs = ^{ex_mem_read, wb_rd, wb_reg_write};
`endif

  // ---------------------------------------------------------------------------
  // Pipeline control outputs, priority: reset > mc_stall > branch > data stall
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    id_ex_bubble  = 1'b0;
    if_id_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
    end else if (mc_stall) begin
      // Whole front end holds; the op stays in EX while MEM receives NOPs.
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      // Wrong-path instructions in IF/ID are squashed; a stall on one of
      // them would be meaningless, so it is dropped.
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
    end else if (data_stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  assign mc_busy = !rst && (mc_state_q == MC_BUSY);

  // ---------------------------------------------------------------------------
  // Private copy of the EX-stage source registers
  // ---------------------------------------------------------------------------
  logic [REG_AW-1:0] ex_rs1_q;
  logic [REG_AW-1:0] ex_rs2_q;

  // Unused sources are recorded as x0 so they can never select a forward.
  always_ff @(posedge clk) begin
    if (rst || id_ex_bubble) begin
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
    end else if (id_ex_en) begin
      ex_rs1_q <= id_use_rs1 ? id_rs1 : '0;
      ex_rs2_q <= id_use_rs2 ? id_rs2 : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand forwarding selects
  // ---------------------------------------------------------------------------
`ifdef HAZARD_CTRL_FWD_EN
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (!rst) begin
      fwd_a = fwd_sel(ex_rs1_q, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
      fwd_b = fwd_sel(ex_rs2_q, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    end
  end
`else
  logic [1:0] unused_fwd_sel;

  // Selects stay on the regfile; the tracked sources are kept so the
  // register copy behaves identically in both builds.
  assign unused_fwd_sel = fwd_sel(ex_rs1_q, mem_rd, mem_reg_write, '0, 1'b0) ^
                          fwd_sel(ex_rs2_q, mem_rd, mem_reg_write, '0, 1'b0);
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif

  // ---------------------------------------------------------------------------
  // Stall performance counter: counts cycles in which the PC is held
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (!pc_en)
      stall_cnt <= sat_inc(stall_cnt);
  end

endmodule
